// File: rtl/alu_ctrl_decoder_pkg.sv
// Shared definitions for the ALU control decoder.
// Holds the opcode/ALU code values, instruction field positions, decoder FSM
// state encodings and small helpers that classify an ALU code.
package alu_ctrl_decoder_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned OpW   = 5;

    // Register-select field positions within an instruction word.
    localparam int unsigned SrcMsb = 10;
    localparam int unsigned SrcLsb = 8;
    localparam int unsigned DstMsb = 7;
    localparam int unsigned DstLsb = 5;

    // Opcode value equals the ALU control code for every legal opcode.
    typedef enum logic [3:0] {
        AluNop  = 4'd0,
        AluNot  = 4'd1,
        AluInc  = 4'd2,
        AluDec  = 4'd3,
        AluMov  = 4'd4,
        AluAdd  = 4'd5,
        AluSub  = 4'd6,
        AluAnd  = 4'd7,
        AluOr   = 4'd8,
        AluIadd = 4'd9,
        AluLdm  = 4'd10,
        AluSetc = 4'd11,
        AluClrc = 4'd12,
        AluLdd  = 4'd13,
        AluStd  = 4'd14
    } alu_code_e;

    localparam int unsigned OpMaxLegal = 14;

    typedef enum logic [0:0] {
        StOp  = 1'b0,
        StImm = 1'b1
    } state_e;

    // True for codes that carry an immediate in a second word.
    function automatic logic is_two_word(input logic [3:0] code);
        return (code == AluIadd) || (code == AluLdm);
    endfunction

    // Codes whose result is written back.
    function automatic logic code_wb_en(input logic [3:0] code);
        return ((code >= AluNot) && (code <= AluLdm)) || (code == AluLdd);
    endfunction

    // Codes that update the carry bit.
    function automatic logic code_upd_c(input logic [3:0] code);
        return ((code >= AluNot) && (code <= AluDec)) ||
               ((code >= AluAdd) && (code <= AluClrc));
    endfunction

    // Codes that update the zero and negative bits.
    function automatic logic code_upd_zn(input logic [3:0] code);
        return ((code >= AluNot) && (code <= AluDec)) ||
               ((code >= AluAdd) && (code <= AluLdm));
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder_ccr_reg.sv
// Condition-code register {C,Z,N}.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   upd_en    - an instruction is retiring from execute this edge
//   code      - ALU code of that instruction (selects which bits update)
//   carry, zero, neg - ALU flag outputs
//   ccr       - {C,Z,N}
module alu_ctrl_decoder_ccr_reg
    import alu_ctrl_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_en,
    input  logic [3:0] code,
    input  logic       carry,
    input  logic       zero,
    input  logic       neg,
    output logic [2:0] ccr
);

    logic [2:0] ccr_q, ccr_d;

    always_comb begin
        ccr_d = ccr_q;
        if (upd_en) begin
            if (code_upd_c(code)) begin
                // SETC/CLRC force carry regardless of the ALU flag.
                if (code == AluSetc) begin
                    ccr_d[2] = 1'b1;
                end else if (code == AluClrc) begin
                    ccr_d[2] = 1'b0;
                end else begin
                    ccr_d[2] = carry;
                end
            end
            if (code_upd_zn(code)) begin
                ccr_d[1] = zero;
                ccr_d[0] = neg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q <= 3'b000;
        end else begin
            ccr_q <= ccr_d;
        end
    end

    assign ccr = ccr_q;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Decode stage for the 16-bit ALU: turns fetched instruction words (one or
// two words for immediate forms) into registered execute-stage controls and
// keeps the condition-code register fed from the ALU flags.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   instr_valid, instr_in   - word from fetch; instr_ready = ~stall
//   stall, flush            - hazard freeze; branch/interrupt flush
//   alu_ctrl, src_sel, dst_sel, imm, wb_en, ex_valid - execute-stage controls
//   illegal                 - pulse when an undefined opcode is accepted
//   alu_carry/zero/neg      - ALU flags; ccr = {C,Z,N}
module alu_ctrl_decoder
    import alu_ctrl_decoder_pkg::*;
#(
    parameter int unsigned N   = DataW,
    parameter int unsigned OPW = OpW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  logic [N-1:0] instr_in,
    output logic         instr_ready,
    input  logic         stall,
    input  logic         flush,
    output logic [3:0]   alu_ctrl,
    output logic [2:0]   src_sel,
    output logic [2:0]   dst_sel,
    output logic [N-1:0] imm,
    output logic         wb_en,
    output logic         ex_valid,
    output logic         illegal,
    input  logic         alu_carry,
    input  logic         alu_zero,
    input  logic         alu_neg,
    output logic [2:0]   ccr
);

    state_e         state_q, state_d;
    logic [3:0]     hold_ctrl_q, hold_ctrl_d;
    logic [2:0]     hold_src_q, hold_src_d;
    logic [2:0]     hold_dst_q, hold_dst_d;
    logic [3:0]     alu_ctrl_q, alu_ctrl_d;
    logic [2:0]     src_sel_q, src_sel_d;
    logic [2:0]     dst_sel_q, dst_sel_d;
    logic [N-1:0]   imm_q, imm_d;
    logic           wb_en_q, wb_en_d;
    logic           ex_valid_q, ex_valid_d;
    logic           illegal_q, illegal_d;

    logic [OPW-1:0] opcode;
    logic [3:0]     code;
    logic [2:0]     word_src;
    logic [2:0]     word_dst;
    logic           legal;
    logic           accept;
    logic           unused_bits;

    assign opcode      = instr_in[N-1 -: OPW];
    assign code        = opcode[3:0];
    assign word_src    = instr_in[SrcMsb:SrcLsb];
    assign word_dst    = instr_in[DstMsb:DstLsb];
    assign legal       = (32'(opcode) <= OpMaxLegal);
    assign unused_bits = ^instr_in[DstLsb-1:0];

    // Flush does not gate readiness; the word is simply dropped on a flush.
    assign instr_ready = ~stall;
    assign accept      = instr_valid & ~stall;

    always_comb begin
        state_d     = state_q;
        hold_ctrl_d = hold_ctrl_q;
        hold_src_d  = hold_src_q;
        hold_dst_d  = hold_dst_q;
        alu_ctrl_d  = alu_ctrl_q;
        src_sel_d   = src_sel_q;
        dst_sel_d   = dst_sel_q;
        imm_d       = imm_q;
        wb_en_d     = wb_en_q;
        ex_valid_d  = ex_valid_q;
        illegal_d   = illegal_q;

        if (flush) begin
            state_d     = StOp;
            hold_ctrl_d = 4'd0;
            hold_src_d  = 3'd0;
            hold_dst_d  = 3'd0;
            alu_ctrl_d  = AluNop;
            wb_en_d     = 1'b0;
            ex_valid_d  = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall) begin
            ex_valid_d = 1'b0;
            illegal_d  = 1'b0;
            if (accept) begin
                unique case (state_q)
                    StOp: begin
                        if (!legal) begin
                            // Undefined opcode issues as a NOP bubble.
                            alu_ctrl_d = AluNop;
                            src_sel_d  = word_src;
                            dst_sel_d  = word_dst;
                            imm_d      = '0;
                            wb_en_d    = 1'b0;
                            ex_valid_d = 1'b1;
                            illegal_d  = 1'b1;
                        end else if (is_two_word(code)) begin
                            hold_ctrl_d = code;
                            hold_src_d  = word_src;
                            hold_dst_d  = word_dst;
                            state_d     = StImm;
                        end else begin
                            alu_ctrl_d = code;
                            src_sel_d  = word_src;
                            dst_sel_d  = word_dst;
                            imm_d      = '0;
                            wb_en_d    = code_wb_en(code);
                            ex_valid_d = 1'b1;
                        end
                    end
                    StImm: begin
                        alu_ctrl_d = hold_ctrl_q;
                        src_sel_d  = hold_src_q;
                        dst_sel_d  = hold_dst_q;
                        imm_d      = instr_in;
                        wb_en_d    = code_wb_en(hold_ctrl_q);
                        ex_valid_d = 1'b1;
                        state_d    = StOp;
                    end
                    default: state_d = StOp;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StOp;
            hold_ctrl_q <= 4'd0;
            hold_src_q  <= 3'd0;
            hold_dst_q  <= 3'd0;
            alu_ctrl_q  <= 4'd0;
            src_sel_q   <= 3'd0;
            dst_sel_q   <= 3'd0;
            imm_q       <= '0;
            wb_en_q     <= 1'b0;
            ex_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_ctrl_q <= hold_ctrl_d;
            hold_src_q  <= hold_src_d;
            hold_dst_q  <= hold_dst_d;
            alu_ctrl_q  <= alu_ctrl_d;
            src_sel_q   <= src_sel_d;
            dst_sel_q   <= dst_sel_d;
            imm_q       <= imm_d;
            wb_en_q     <= wb_en_d;
            ex_valid_q  <= ex_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    // The instruction in execute retires (and updates flags) on any
    // non-stalled edge, including a flush edge.
    alu_ctrl_decoder_ccr_reg u_ccr_reg (
        .clk    (clk),
        .rst    (rst),
        .upd_en (ex_valid_q & ~stall),
        .code   (alu_ctrl_q),
        .carry  (alu_carry),
        .zero   (alu_zero),
        .neg    (alu_neg),
        .ccr    (ccr)
    );

    assign alu_ctrl = alu_ctrl_q;
    assign src_sel  = src_sel_q;
    assign dst_sel  = dst_sel_q;
    assign imm      = imm_q;
    assign wb_en    = wb_en_q;
    assign ex_valid = ex_valid_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
module tb_alu_ctrl_decoder;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic [N-1:0] instr_in = '0;
    logic         instr_ready;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   alu_ctrl;
    logic [2:0]   src_sel;
    logic [2:0]   dst_sel;
    logic [N-1:0] imm;
    logic         wb_en;
    logic         ex_valid;
    logic         illegal;
    logic         alu_carry = 1'b0;
    logic         alu_zero = 1'b0;
    logic         alu_neg = 1'b0;
    logic [2:0]   ccr;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string        tag;
        logic [3:0]   ctrl;
        logic [2:0]   src;
        logic [2:0]   dst;
        logic [N-1:0] imm;
        logic         wb;
        logic         exv;
        logic         ill;
        logic [2:0]   ccr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .instr_ready (instr_ready),
        .stall       (stall),
        .flush       (flush),
        .alu_ctrl    (alu_ctrl),
        .src_sel     (src_sel),
        .dst_sel     (dst_sel),
        .imm         (imm),
        .wb_en       (wb_en),
        .ex_valid    (ex_valid),
        .illegal     (illegal),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .ccr         (ccr)
    );

    task automatic chk(input string tag, input string fld, input logic [N-1:0] obs,
                       input logic [N-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge,
    // then compare them #1 after that edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [N-1:0] w,
                        input logic s, input logic f, input logic [2:0] flags,
                        input logic [3:0] e_ctrl, input logic [2:0] e_src,
                        input logic [2:0] e_dst, input logic [N-1:0] e_imm, input logic e_wb,
                        input logic e_exv, input logic e_ill, input logic [2:0] e_ccr);
        exp_t e;
        exp_t got;
        rst         = r;
        instr_valid = v;
        instr_in    = w;
        stall       = s;
        flush       = f;
        {alu_carry, alu_zero, alu_neg} = flags;
        e.tag  = tag;
        e.ctrl = e_ctrl;
        e.src  = e_src;
        e.dst  = e_dst;
        e.imm  = e_imm;
        e.wb   = e_wb;
        e.exv  = e_exv;
        e.ill  = e_ill;
        e.ccr  = e_ccr;
        sb.push_back(e);
        #1;
        chk(tag, "instr_ready", {15'd0, instr_ready}, {15'd0, ~s});
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk(got.tag, "alu_ctrl", {12'd0, alu_ctrl}, {12'd0, got.ctrl});
        chk(got.tag, "src_sel", {13'd0, src_sel}, {13'd0, got.src});
        chk(got.tag, "dst_sel", {13'd0, dst_sel}, {13'd0, got.dst});
        chk(got.tag, "imm", imm, got.imm);
        chk(got.tag, "wb_en", {15'd0, wb_en}, {15'd0, got.wb});
        chk(got.tag, "ex_valid", {15'd0, ex_valid}, {15'd0, got.exv});
        chk(got.tag, "illegal", {15'd0, illegal}, {15'd0, got.ill});
        chk(got.tag, "ccr", {13'd0, ccr}, {13'd0, got.ccr});
    endtask

    initial begin
        @(posedge clk);
        #1;
        //    tag          rst v  word     s  f  CZN      ctrl src dst imm      wb exv ill ccr
        step("reset",      1, 0, 16'h0000, 0, 0, 3'b000, 0,  0, 0, 16'h0000, 0, 0, 0, 3'b000);
        step("add",        0, 1, 16'h2940, 0, 0, 3'b000, 5,  1, 2, 16'h0000, 1, 1, 0, 3'b000);
        step("add_idle",   0, 0, 16'h0000, 0, 0, 3'b101, 5,  1, 2, 16'h0000, 1, 0, 0, 3'b101);
        step("ldm_w1",     0, 1, 16'h5060, 0, 0, 3'b000, 5,  1, 2, 16'h0000, 1, 0, 0, 3'b101);
        step("ldm_w2",     0, 1, 16'hBEEF, 0, 0, 3'b000, 10, 0, 3, 16'hBEEF, 1, 1, 0, 3'b101);
        step("iadd_w1",    0, 1, 16'h4A80, 0, 0, 3'b010, 10, 0, 3, 16'hBEEF, 1, 0, 0, 3'b010);
        step("flush_imm",  0, 1, 16'h1234, 0, 1, 3'b111, 0,  0, 3, 16'hBEEF, 0, 0, 0, 3'b010);
        step("not_after",  0, 1, 16'h0800, 0, 0, 3'b111, 1,  0, 0, 16'h0000, 1, 1, 0, 3'b010);
        step("sub",        0, 1, 16'h3320, 0, 0, 3'b101, 6,  3, 1, 16'h0000, 1, 1, 0, 3'b101);
        step("stall1",     0, 1, 16'h2940, 1, 0, 3'b110, 6,  3, 1, 16'h0000, 1, 1, 0, 3'b101);
        step("stall2",     0, 1, 16'h2940, 1, 0, 3'b110, 6,  3, 1, 16'h0000, 1, 1, 0, 3'b101);
        step("stall3",     0, 1, 16'h2940, 1, 0, 3'b110, 6,  3, 1, 16'h0000, 1, 1, 0, 3'b101);
        step("stall_rel",  0, 0, 16'h0000, 0, 0, 3'b110, 6,  3, 1, 16'h0000, 1, 0, 0, 3'b110);
        step("clrc",       0, 1, 16'h6000, 0, 0, 3'b100, 12, 0, 0, 16'h0000, 0, 1, 0, 3'b110);
        step("setc",       0, 1, 16'h5800, 0, 0, 3'b101, 11, 0, 0, 16'h0000, 0, 1, 0, 3'b010);
        step("mov",        0, 1, 16'h2120, 0, 0, 3'b001, 4,  1, 1, 16'h0000, 1, 1, 0, 3'b110);
        step("mov_idle",   0, 0, 16'h0000, 0, 0, 3'b001, 4,  1, 1, 16'h0000, 1, 0, 0, 3'b110);
        step("illegal20",  0, 1, 16'hA260, 0, 0, 3'b000, 0,  2, 3, 16'h0000, 0, 1, 1, 3'b110);
        step("ill_idle",   0, 0, 16'h0000, 0, 0, 3'b111, 0,  2, 3, 16'h0000, 0, 0, 0, 3'b110);
        step("iadd_w1b",   0, 1, 16'h4A80, 0, 0, 3'b000, 0,  2, 3, 16'h0000, 0, 0, 0, 3'b110);
        step("rst_imm",    1, 1, 16'h0005, 0, 0, 3'b000, 0,  0, 0, 16'h0000, 0, 0, 0, 3'b000);
        step("not_post",   0, 1, 16'h0800, 0, 0, 3'b000, 1,  0, 0, 16'h0000, 1, 1, 0, 3'b000);
        step("sub2",       0, 1, 16'h3320, 0, 0, 3'b010, 6,  3, 1, 16'h0000, 1, 1, 0, 3'b010);
        step("stall_flsh", 0, 1, 16'h2940, 1, 1, 3'b101, 0,  3, 1, 16'h0000, 0, 0, 0, 3'b010);
        step("post_flsh",  0, 0, 16'h0000, 0, 0, 3'b101, 0,  3, 1, 16'h0000, 0, 0, 0, 3'b010);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
